// File: rtl/multicycle_datapath.sv
// multicycle_datapath
// Multi-cycle RV32I core: datapath plus FETCH/DECODE/EXEC/MEM/WB/HALT controller
// sharing one single-ported memory with a req/ready handshake.
// Optional feature: define PERF_CNT_EN to build the cycle and retired-instruction
// counters; otherwise cycle_cnt and instret_cnt are tied to 0.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   mem_req/we/addr/be    - memory request, write flag, word-aligned address, byte enables
//   mem_wdata/rdata/ready - store data (lane-replicated), read data, access accept
//   dbg_reg_sel/data      - combinational register-file debug read
//   pc_out, instr_out     - current PC and latched IR
//   state_out, halted     - FSM state encoding, HALT indicator
//   cycle_cnt/instret_cnt - performance counters
`timescale 1ns/1ps
module multicycle_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    input  logic [4:0]        dbg_reg_sel,
    output logic [31:0]       dbg_reg_data,
    output logic [31:0]       pc_out,
    output logic [31:0]       instr_out,
    output logic [2:0]        state_out,
    output logic              halted,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instret_cnt
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpMisc   = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] ea_q, ea_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] rf_q [32];

    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [31:0] addr_full;

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       is_store;

    assign opcode    = ir_q[6:0];
    assign rd        = ir_q[11:7];
    assign funct3    = ir_q[14:12];
    assign rs1       = ir_q[19:15];
    assign rs2       = ir_q[24:20];
    assign funct7_b5 = ir_q[30];
    assign is_store  = (opcode == OpStore);

    // Immediate generator
    logic [31:0] imm_gen;
    always_comb begin
        imm_gen = '0;
        case (opcode)
            OpImm, OpLoad, OpJalr: imm_gen = {{20{ir_q[31]}}, ir_q[31:20]};
            OpStore:  imm_gen = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            OpBranch: imm_gen = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                                 ir_q[11:8], 1'b0};
            OpLui, OpAuipc: imm_gen = {ir_q[31:12], 12'b0};
            OpJal:    imm_gen = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20],
                                 ir_q[30:21], 1'b0};
            default:  imm_gen = '0;
        endcase
    end

    // ALU: register-register uses B, register-immediate uses IMM.
    // ir[30] selects SUB only for OP, but SRA/SRAI for both forms.
    logic [31:0] op2, alu_res;
    logic [4:0]  shamt;
    assign op2   = (opcode == OpReg) ? b_q : imm_q;
    assign shamt = op2[4:0];

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'd0: alu_res = (opcode == OpReg && funct7_b5) ? a_q - op2 : a_q + op2;
            3'd1: alu_res = a_q << shamt;
            3'd2: alu_res = ($signed(a_q) < $signed(op2)) ? 32'd1 : 32'd0;
            3'd3: alu_res = (a_q < op2) ? 32'd1 : 32'd0;
            3'd4: alu_res = a_q ^ op2;
            3'd5: alu_res = funct7_b5 ? $unsigned($signed(a_q) >>> shamt) : a_q >> shamt;
            3'd6: alu_res = a_q | op2;
            3'd7: alu_res = a_q & op2;
            default: alu_res = '0;
        endcase
    end

    // Branch compare: flags from A - B; carry set means no borrow (A >= B unsigned)
    logic [32:0] diff_full;
    logic        flag_z, flag_s, flag_c, flag_v, br_taken;
    assign diff_full = {1'b0, a_q} + {1'b0, ~b_q} + 33'd1;
    assign flag_z    = (diff_full[31:0] == 32'd0);
    assign flag_s    = diff_full[31];
    assign flag_c    = diff_full[32];
    assign flag_v    = (a_q[31] != b_q[31]) && (diff_full[31] != a_q[31]);

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'd0: br_taken = flag_z;
            3'd1: br_taken = !flag_z;
            3'd4: br_taken = flag_s ^ flag_v;
            3'd5: br_taken = !(flag_s ^ flag_v);
            3'd6: br_taken = !flag_c;
            3'd7: br_taken = flag_c;
            default: br_taken = 1'b0;
        endcase
    end

    // Effective address and alignment
    logic [31:0] ea;
    logic        misaligned;
    assign ea         = a_q + imm_q;
    assign misaligned = (funct3[1:0] == 2'b01 && ea[0]) || (funct3[1] && ea[1:0] != 2'b00);

    // Load lane extraction from MDR
    logic [31:0] lane, load_val;
    assign lane = mdr_q >> {ea_q[1:0], 3'b000};
    always_comb begin
        case (funct3)
            3'd0:    load_val = {{24{lane[7]}}, lane[7:0]};
            3'd1:    load_val = {{16{lane[15]}}, lane[15:0]};
            3'd4:    load_val = {24'b0, lane[7:0]};
            3'd5:    load_val = {16'b0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    // Store byte enables and lane-replicated data
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                store_be    = 4'b0001 << ea_q[1:0];
                store_wdata = {4{b_q[7:0]}};
            end
            2'b01: begin
                store_be    = ea_q[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{b_q[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = b_q;
            end
        endcase
    end

    // Next-state and Moore memory outputs
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        ea_d      = ea_q;
        mdr_d     = mdr_q;
        rf_we     = 1'b0;
        rf_wdata  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_full = pc_q;

        case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d   = rf_q[rs1];
                b_d   = rf_q[rs2];
                imm_d = imm_gen;
                state_d = (opcode == OpSystem || opcode == OpMisc) ? StHalt : StExec;
            end
            StExec: begin
                // Non-memory default: sequential PC, retire, back to FETCH
                state_d = StFetch;
                pc_d    = pc_q + 32'd4;
                case (opcode)
                    OpLoad, OpStore: begin
                        pc_d = pc_q;
                        if (misaligned) begin
                            state_d = StHalt;
                        end else begin
                            ea_d    = ea;
                            state_d = StMem;
                        end
                    end
                    OpBranch: if (br_taken) pc_d = pc_q + imm_q;
                    OpJal: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_q + 32'd4;
                        pc_d     = pc_q + imm_q;
                    end
                    OpJalr: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_q + 32'd4;
                        pc_d     = ea & 32'hFFFF_FFFE;
                    end
                    OpLui: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm_q;
                    end
                    OpAuipc: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_q + imm_q;
                    end
                    OpImm, OpReg: begin
                        rf_we    = 1'b1;
                        rf_wdata = alu_res;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                mem_req   = 1'b1;
                mem_we    = is_store;
                addr_full = ea_q;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = StFetch;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                rf_we    = 1'b1;
                rf_wdata = load_val;
                pc_d     = pc_q + 32'd4;
                state_d  = StFetch;
            end
            StHalt: ;
            default: state_d = StHalt;
        endcase
    end

    logic [31:0] addr_word;
    assign addr_word    = addr_full & 32'hFFFF_FFFC;
    assign mem_addr     = addr_word[ADDR_W-1:0];
    assign mem_be       = (state_q == StMem && is_store) ? store_be : 4'b1111;
    assign mem_wdata    = store_wdata;
    assign dbg_reg_data = rf_q[dbg_reg_sel];
    assign pc_out       = pc_q;
    assign instr_out    = ir_q;
    assign state_out    = state_q;
    assign halted       = (state_q == StHalt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            ea_q    <= '0;
            mdr_q   <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            ea_q    <= ea_d;
            mdr_q   <= mdr_d;
            // x0 stays hard-wired to zero
            if (rf_we && rd != 5'd0) rf_q[rd] <= rf_wdata;
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] cycle_q, instret_q;
    logic        retire;
    // Every transition back to FETCH from EXEC, MEM or WB completes an instruction
    assign retire = (state_d == StFetch) &&
                    (state_q == StExec || state_q == StMem || state_q == StWb);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != StHalt) cycle_q <= cycle_q + 32'd1;
            if (retire) instret_q <= instret_q + 32'd1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
`timescale 1ns/1ps
module tb_multicycle_datapath;

    localparam logic [31:0] OpLoad  = 32'h03;
    localparam logic [31:0] OpImm   = 32'h13;
    localparam logic [31:0] OpAuipc = 32'h17;
    localparam logic [31:0] OpLui   = 32'h37;
    localparam logic [31:0] OpJalr  = 32'h67;
    localparam logic [31:0] Ecall   = 32'h0000_0073;
    localparam int NVec = 17;

    logic        clk, reset;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [4:0]  dbg_reg_sel;
    logic [31:0] dbg_reg_data, pc_out, instr_out, cycle_cnt, instret_cnt;
    logic [2:0]  state_out;

    logic [31:0] mem [128];
    assign mem_rdata = mem[mem_addr[8:2]];

    multicycle_datapath #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .dbg_reg_sel(dbg_reg_sel), .dbg_reg_data(dbg_reg_data),
        .pc_out(pc_out), .instr_out(instr_out), .state_out(state_out), .halted(halted),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [NVec];
    logic [31:0] exp_q [$];

    function automatic logic [31:0] enc_i(logic [31:0] imm, logic [31:0] rs1, logic [31:0] f3,
                                          logic [31:0] rd, logic [31:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(logic [31:0] imm, logic [31:0] rs2, logic [31:0] rs1,
                                          logic [31:0] f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(logic [31:0] imm, logic [31:0] rs2, logic [31:0] rs1,
                                          logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_r(logic [31:0] f7, logic [31:0] rs2, logic [31:0] rs1,
                                          logic [31:0] f3, logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_u(logic [31:0] imm, logic [31:0] rd, logic [31:0] op);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_j(logic [31:0] imm, logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: sample the write request before the edge, apply it at the edge,
    // return on the following falling edge.
    task automatic tick();
        logic        wr;
        logic [31:0] wa, wd;
        logic [3:0]  wbe;
        wr  = mem_req && mem_ready && mem_we && !reset;
        wa  = mem_addr;
        wd  = mem_wdata;
        wbe = mem_be;
        @(posedge clk);
        if (wr) begin
            for (int k = 0; k < 4; k++) if (wbe[k]) mem[wa[8:2]][8*k +: 8] = wd[8*k +: 8];
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = Ecall;
    endtask

    task automatic run_to_halt(input int limit);
        while (!halted && cyc < limit) tick();
        check("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic read_reg(input int r, output logic [31:0] v);
        dbg_reg_sel = r[4:0];
        #1;
        v = dbg_reg_data;
    endtask

    task automatic branch_test(input logic [31:0] v7, input logic [31:0] exp_pc, input string nm);
        clear_mem();
        mem[0]  = enc_i(7, 0, 0, 6, OpImm);
        mem[1]  = enc_i(v7, 0, 0, 7, OpImm);
        mem[2]  = enc_j(32'h38, 0);           // 0x08 -> 0x40
        mem[16] = enc_b(-16, 7, 6, 0);        // beq x6,x7,-16 at 0x40
        do_reset();
        run_to_halt(60);
        check(nm, pc_out, exp_pc);
    endtask

    logic [31:0] v;
    int          mem_cnt;

    initial begin
        reset       = 1'b1;
        mem_ready   = 1'b1;
        dbg_reg_sel = '0;
        clear_mem();

        // ---------------- table-driven ALU vectors (x3 = op(x1, x2)) -------------
        vecs[0]  = '{"add",   enc_r(0, 2, 1, 0, 3),  32'h7FFF_FFFF, 32'h1,         32'h8000_0000};
        vecs[1]  = '{"sub",   enc_r(32, 2, 1, 0, 3), 32'd5,         32'd7,         32'hFFFF_FFFE};
        vecs[2]  = '{"sll",   enc_r(0, 2, 1, 1, 3),  32'h1,         32'h21,        32'h2};
        vecs[3]  = '{"slt",   enc_r(0, 2, 1, 2, 3),  32'hFFFF_FFFF, 32'h1,         32'h1};
        vecs[4]  = '{"sltu",  enc_r(0, 2, 1, 3, 3),  32'hFFFF_FFFF, 32'h1,         32'h0};
        vecs[5]  = '{"xor",   enc_r(0, 2, 1, 4, 3),  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00};
        vecs[6]  = '{"srl",   enc_r(0, 2, 1, 5, 3),  32'h8000_0000, 32'h4,         32'h0800_0000};
        vecs[7]  = '{"sra",   enc_r(32, 2, 1, 5, 3), 32'h8000_0000, 32'h4,         32'hF800_0000};
        vecs[8]  = '{"or",    enc_r(0, 2, 1, 6, 3),  32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0};
        vecs[9]  = '{"and",   enc_r(0, 2, 1, 7, 3),  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00};
        vecs[10] = '{"addi",  enc_i(-1, 1, 0, 3, OpImm),     32'h0,         32'h0, 32'hFFFF_FFFF};
        vecs[11] = '{"srai",  enc_i(32'h41F, 1, 5, 3, OpImm), 32'h8000_0000, 32'h0, 32'hFFFF_FFFF};
        vecs[12] = '{"slti",  enc_i(-1, 1, 2, 3, OpImm),     32'hFFFF_FFFE, 32'h0, 32'h1};
        vecs[13] = '{"sltiu", enc_i(-1, 1, 3, 3, OpImm),     32'd5,         32'h0, 32'h1};
        vecs[14] = '{"lui",   enc_u(32'h12345, 3, OpLui),    32'h0,         32'h0, 32'h1234_5000};
        vecs[15] = '{"xori",  enc_i(-1, 1, 4, 3, OpImm),     32'h0F0F_0F0F, 32'h0, 32'hF0F0_F0F0};
        vecs[16] = '{"auipc", enc_u(32'h1, 3, OpAuipc),      32'h0,         32'h0, 32'h0000_1008};

        for (int i = 0; i < NVec; i++) begin
            clear_mem();
            mem[0]  = enc_i(32'h100, 0, 2, 1, OpLoad);  // lw x1,0x100(x0)
            mem[1]  = enc_i(32'h104, 0, 2, 2, OpLoad);  // lw x2,0x104(x0)
            mem[2]  = vecs[i].instr;
            mem[64] = vecs[i].a;
            mem[65] = vecs[i].b;
            exp_q.push_back(vecs[i].exp);
            do_reset();
            run_to_halt(60);
            read_reg(3, v);
            check(vecs[i].name, v, exp_q.pop_front());
        end

        // ---------------- reset state + addi/addi/ecall ---------------------------
        clear_mem();
        mem[0] = enc_i(5, 0, 0, 1, OpImm);
        mem[1] = enc_i(-3, 1, 0, 2, OpImm);
        do_reset();
        check("rst_mem_req",   32'(mem_req),   32'd1);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_be",    32'(mem_be),    32'hF);
        check("rst_mem_addr",  mem_addr,       32'h0);
        check("rst_mem_wdata", mem_wdata,      32'h0);
        check("rst_halted",    32'(halted),    32'd0);
        check("rst_state",     32'(state_out), 32'd0);
        check("rst_instr",     instr_out,      32'h0);
        run_to_halt(40);
        check("prog_halt_cycle", cyc, 32'd8);
        check("prog_pc", pc_out, 32'h8);
        read_reg(1, v); check("prog_x1", v, 32'd5);
        read_reg(2, v); check("prog_x2", v, 32'd2);
`ifdef PERF_CNT_EN
        check("prog_instret", instret_cnt, 32'd2);
        check("prog_cycles",  cycle_cnt,   32'd8);
`else
        check("prog_instret_off", instret_cnt, 32'd0);
        check("prog_cycles_off",  cycle_cnt,   32'd0);
`endif

        // ---------------- FETCH wait states ---------------------------------------
        mem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check("fwait_req",   32'(mem_req), 32'd1);
            check("fwait_addr",  mem_addr,     32'h0);
            check("fwait_pc",    pc_out,       32'h0);
            check("fwait_instr", instr_out,    32'h0);
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        check("fwait_ir_latched", instr_out, mem[0]);
        check("fwait_decode", 32'(state_out), 32'd1);
        run_to_halt(40);
        check("fwait_halt_cycle", cyc, 32'd11);

        // ---------------- sb / lb / lbu -------------------------------------------
        clear_mem();
        mem[0] = enc_i(32'hA5, 0, 0, 2, OpImm);   // addi x2,x0,0xA5
        mem[1] = enc_s(3, 2, 0, 0);               // sb x2,3(x0)
        mem[2] = enc_i(3, 0, 0, 3, OpLoad);       // lb x3,3(x0)
        mem[3] = enc_i(3, 0, 4, 4, OpLoad);       // lbu x4,3(x0)
        do_reset();
        while (!(state_out == 3'd3 && mem_we) && cyc < 20) tick();
        check("sb_cycle", cyc, 32'd6);
        check("sb_we",    32'(mem_we), 32'd1);
        check("sb_be",    32'(mem_be), 32'h8);
        check("sb_wdata", mem_wdata,   32'hA5A5_A5A5);
        check("sb_addr",  mem_addr,    32'h0);
        run_to_halt(60);
        check("ldst_halt_cycle", cyc, 32'd19);
        read_reg(3, v); check("lb_x3",  v, 32'hFFFF_FFA5);
        read_reg(4, v); check("lbu_x4", v, 32'h0000_00A5);

        // ---------------- jalr / beq ----------------------------------------------
        clear_mem();
        mem[0] = enc_i(32'h100, 0, 0, 5, OpImm);  // addi x5,x0,0x100
        mem[1] = enc_j(32'h1C, 0);                // 0x04 -> 0x20
        mem[8] = enc_i(7, 5, 0, 1, OpJalr);       // jalr x1,7(x5) at 0x20
        do_reset();
        run_to_halt(60);
        check("jalr_pc", pc_out, 32'h106);
        read_reg(1, v); check("jalr_x1", v, 32'h24);
        branch_test(32'd7, 32'h30, "beq_taken_pc");
        branch_test(32'd8, 32'h44, "beq_not_taken_pc");

        // ---------------- misaligned lw -------------------------------------------
        clear_mem();
        mem[0] = enc_i(32'h102, 0, 0, 4, OpImm);  // addi x4,x0,0x102
        mem[1] = enc_i(9, 0, 0, 6, OpImm);        // addi x6,x0,9
        mem[2] = enc_i(0, 4, 2, 6, OpLoad);       // lw x6,0(x4)
        do_reset();
        mem_cnt = 0;
        while (!halted && cyc < 40) begin
            if (state_out == 3'd3) mem_cnt++;
            tick();
        end
        check("mis_halted",     32'(halted),  32'd1);
        check("mis_halt_cycle", cyc,          32'd9);
        check("mis_no_mem",     mem_cnt,      32'd0);
        check("mis_req_low",    32'(mem_req), 32'd0);
        read_reg(6, v); check("mis_x6", v, 32'd9);

        // ---------------- reset during a MEM store wait ---------------------------
        clear_mem();
        mem[0] = enc_i(32'h55, 0, 0, 2, OpImm);   // addi x2,x0,0x55
        mem[1] = enc_s(32'h40, 2, 0, 2);          // sw x2,0x40(x0)
        do_reset();
        while (state_out != 3'd3 && cyc < 20) tick();
        check("rmem_in_mem", 32'(state_out), 32'd3);
        mem_ready = 1'b0;
        read_reg(2, v); check("rmem_x2_before", v, 32'h55);
        tick();
        tick();
        check("rmem_req_held", 32'(mem_req), 32'd1);
        check("rmem_we_held",  32'(mem_we),  32'd1);
        check("rmem_addr",     mem_addr,     32'h40);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rmem_state", 32'(state_out), 32'd0);
        check("rmem_we",    32'(mem_we),    32'd0);
        check("rmem_addr_reset", mem_addr,  32'h0);
        check("rmem_no_write", mem[16], Ecall);
        for (int r = 0; r < 32; r++) begin
            read_reg(r, v);
            check("rmem_reg_zero", v, 32'h0);
        end
        @(negedge clk);
        mem_ready = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Multi-cycle RV32I core datapath and controller. It is the next generation of the single-cycle femtoRV32 datapath. A state machine replaces the single-cycle flow, and one unified, single-ported memory interface with a ready handshake replaces the separate instruction and data memories. This lets the block sit in front of slow or shared memory and tolerate wait states. It is the top of the core, and the FPGA wrapper and memory model connect directly to it.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `ADDR_W`, default `32`: width of `mem_addr`. Upper PC bits beyond this width are dropped.
- `clk` in, 1: system clock. All state changes on the rising edge.
- `reset` in, 1: synchronous, active-high reset.
- `mem_req` out, 1: memory access request, held until accepted.
- `mem_we` out, 1: 1 = write, 0 = read. Valid while `mem_req` is high.
- `mem_addr` out, `ADDR_W`: byte address, word-aligned (bits [1:0] = 0).
- `mem_be` out, 4: byte enables for a write; 4'b1111 on reads.
- `mem_wdata` out, 32: store data, replicated across the byte lanes.
- `mem_rdata` in, 32: read data, valid in the cycle where `mem_ready` is high.
- `mem_ready` in, 1: the access completes on any edge where `mem_req` and `mem_ready` are both high.
- `dbg_reg_sel` in, 5: register-file debug read address.
- `dbg_reg_data` out, 32: combinational read of `x[dbg_reg_sel]`.
- `pc_out` out, 32: current PC.
- `instr_out` out, 32: latched IR.
- `state_out` out, 3: current FSM state encoding.
- `halted` out, 1: high while the core is in HALT.
- `cycle_cnt` out, 32: cycle counter (see Configuration).
- `instret_cnt` out, 32: retired-instruction counter (see Configuration).

## Operation
- Supports the full RV32I set except the SYSTEM and MISC-MEM opcodes. x0 reads as 0 and writes to it are ignored.
- FSM states and encodings:
  - FETCH (0): `mem_req=1`, `mem_we=0`, `mem_addr=PC`. On accept, latch IR ← `mem_rdata` and go to DECODE.
  - DECODE (1): latch A ← rs1, B ← rs2, IMM ← immgen(IR).
    - SYSTEM or MISC-MEM opcode (ECALL, EBREAK, FENCE, FENCE.I): go to HALT.
    - Otherwise go to EXEC.
  - EXEC (2): compute the ALU result.
    - Branches use the Z/S/C/V flags and funct3.
    - JAL target = PC+imm. JALR target = (A+imm) & ~1.
    - LUI writes IMM. AUIPC writes PC+IMM. JAL/JALR write PC+4.
    - Non-memory instructions: write rd, update PC, retire, go to FETCH.
    - Load/store with an aligned effective address: latch the address and go to MEM.
    - Misaligned load/store: go to HALT, no access issued. Halfword requires ea[0]=0; word requires ea[1:0]=0.
  - MEM (3): `mem_req=1`.
    - Store: `mem_we=1`, `mem_be` is selected by size and ea[1:0]. On accept, PC ← PC+4, retire, go to FETCH.
    - Load: on accept, latch the data into MDR and go to WB.
  - WB (4): rd ← MDR lane selected by ea[1:0], sign- or zero-extended per funct3 (LB/LH/LW/LBU/LHU). PC ← PC+4, retire, go to FETCH.
  - HALT (5): terminal state. `mem_req=0`. Only `reset` exits it.
- Arithmetic is 32-bit with wrap-around. Shifts use the low 5 bits of the shift amount. SLT/SLTU compare signed/unsigned respectively.

## Timing
- Reset values: state FETCH, PC=`RESET_PC`, all registers 0, IR 0, counters 0.
  - Output consequence: `mem_req=1`, `mem_we=0`, `mem_be=4'b1111`, `mem_addr=RESET_PC`, `mem_wdata=0`, `halted=0`, `state_out=0`.
- `mem_req` and the address, data and enables are Moore outputs of state plus latched registers. They are stable for the entire wait period.
- Latency with `mem_ready` tied high:
  - ALU, branch, jump, LUI, AUIPC: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle in FETCH or MEM adds 1 cycle.
- A request is never withdrawn before it is accepted, except by reset.
- Reset asserted in any state, including the middle of a MEM wait, takes effect at that edge. The next cycle is FETCH at `RESET_PC` with `mem_we=0`.
- The register file writes on the edge that leaves EXEC or WB. `dbg_reg_data` reflects the new value in the following cycle.

## Configuration
- `PERF_CNT_EN` defined:
  - `cycle_cnt` increments every cycle that is not reset and not HALT.
  - `instret_cnt` increments on each retiring edge (EXEC or MEM-store or WB into FETCH).
  - Both wrap at 2^32.
- `PERF_CNT_EN` undefined: both counters and their logic are removed, and both outputs are tied to 0.

## Test plan
- Program `addi x1,x0,5` / `addi x2,x1,-3` / `ecall`, with `mem_ready`=1 → x1=5, x2=2. `halted` rises in cycle 8 after reset and `pc_out` holds at 8. With `PERF_CNT_EN`, `instret_cnt`=2 and `cycle_cnt`=8.
- Hold `mem_ready`=0 for 3 cycles in FETCH → `mem_req`=1 and `mem_addr`=PC are held constant for 4 cycles, and PC and IR are unchanged until acceptance.
- x2=0x000000A5, `sb x2,3(x0)` → `mem_we`=1, `mem_be`=4'b1000, `mem_wdata`=0xA5A5A5A5, `mem_addr`=0.
  - Then `lb x3,3(x0)` with `mem_rdata`=0xA5000000 → x3=0xFFFFFFA5.
  - `lbu` on the same data → x3=0x000000A5.
- x5=0x100, `jalr x1,7(x5)` at PC=0x20 → PC=0x106, x1=0x24. `beq` with equal operands at PC=0x40, imm=-16 → PC=0x30. Unequal operands → PC=0x44.
- x4=0x102, `lw x6,0(x4)` → no `mem_req` in MEM, `halted`=1, x6 unchanged.
- Assert `reset` for one cycle mid-MEM wait during a store → the next cycle has `state_out`=0, `mem_we`=0, `mem_addr`=`RESET_PC`, and all `dbg_reg_data` reads return 0.
